// File: rtl/regfile_write_port.sv
// Write side of the 16 x 8-bit register bank.
// Requests are buffered in a small in-order FIFO and committed one per cycle
// into the bank. Register 0 reads as zero and is never written.
// A pending bitmap marks every register with a buffered write, so readers
// can detect read-after-write hazards.
//
// Handshake: a request transfers on a rising edge where wr_valid and wr_ready
// are both high. wr_ready is derived only from buffer occupancy (never from
// wr_valid). Once wr_valid is raised, the producer holds wr_valid, wa and wd
// stable until the transfer happens.
module regfile_write_port #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wa,
  input  logic [7:0]       wd,
  input  logic             commit_en,
  input  logic             clr,
  output logic [127:0]     regOut,
  output logic [15:0]      pending,
  output logic [CNT_W-1:0] commit_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  // The extra MSB on each pointer tells full apart from empty.
  logic [PTR_W:0]   wrPtr;
  logic [PTR_W:0]   rdPtr;
  logic [PTR_W:0]   occupancy;
  logic [3:0]       addrMem [DEPTH];
  logic [7:0]       dataMem [DEPTH];
  logic [7:0]       bank [1:15];
  logic [CNT_W-1:0] commitCnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [3:0]       headAddr;
  logic [7:0]       headData;
  logic [PTR_W-1:0] pendSlot;
  logic [15:0]      pendVec;

  assign full      = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign empty     = (wrPtr == rdPtr);
  assign occupancy = wrPtr - rdPtr;
  assign wr_ready  = !full;

  // clr drops any push or pop presented in the same cycle.
  assign push      = wr_valid && !full && !clr;
  assign pop       = commit_en && !empty && !clr;
  assign headAddr  = addrMem[rdPtr[PTR_W-1:0]];
  assign headData  = dataMem[rdPtr[PTR_W-1:0]];

  // Pending bitmap: one-hot OR of the addresses of all live buffer entries.
  always_comb begin
    pendVec  = '0;
    pendSlot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pendSlot = rdPtr[PTR_W-1:0] + PTR_W'(k);
      if ((PTR_W + 1)'(k) < occupancy) begin
        pendVec[addrMem[pendSlot]] = 1'b1;
      end
    end
    // Register 0 can never be the target of a real write.
    pendVec[0] = 1'b0;
  end

  assign pending = pendVec;

  // Buffer payload storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr[PTR_W-1:0]] <= wa;
      dataMem[wrPtr[PTR_W-1:0]] <= wd;
    end
  end

  // Pointers, bank and commit counter; a head addressed to 0 is popped and discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      commitCnt <= '0;
      for (int r = 1; r < 16; r++) begin
        bank[r] <= 8'h00;
      end
    end else if (clr) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      commitCnt <= '0;
      for (int r = 1; r < 16; r++) begin
        bank[r] <= 8'h00;
      end
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        if (headAddr != 4'd0) begin
          commitCnt <= commitCnt + CNT_W'(1);
        end
        for (int r = 1; r < 16; r++) begin
          if (headAddr == 4'(r)) begin
            bank[r] <= headData;
          end
        end
      end
    end
  end

  assign commit_cnt = commitCnt;

  // Flatten the bank; register 0 is constant zero.
  assign regOut[7:0] = 8'h00;
  for (genvar g = 1; g < 16; g++) begin : g_flat
    assign regOut[8*g +: 8] = bank[g];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed vector table, hand-written
// multi-cycle sequences (mid-stream reset, long burst with counter wrap) and a
// randomized phase checked against a queue-based reference model.
module tb_regfile_write_port;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic [3:0]       wa = 4'h0;
  logic [7:0]       wd = 8'h00;
  logic             commit_en = 1'b0;
  logic             clr = 1'b0;
  logic             wr_ready;
  logic [127:0]     regOut;
  logic [15:0]      pending;
  logic [CNT_W-1:0] commit_cnt;

  regfile_write_port #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wa         (wa),
    .wd         (wd),
    .commit_en  (commit_en),
    .clr        (clr),
    .regOut     (regOut),
    .pending    (pending),
    .commit_cnt (commit_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [7:0]  d;
    logic        ce;
    logic        cl;
    logic        rdy;   // expected wr_ready before the edge
    logic [15:0] pend;  // expected pending before the edge
    logic [3:0]  ca;    // register inspected after the edge
    logic [7:0]  cb;    // its expected value
    logic [7:0]  cnt;   // expected commit_cnt after the edge
  } vec_t;

  vec_t vecs [18];

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [11:0] expQ [$];
  logic [7:0]  mBank [16];
  int          mCnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [7:0] d,
                       input logic ce, input logic cl);
    wr_valid  = v;
    wa        = a;
    wd        = d;
    commit_en = ce;
    clr       = cl;
  endtask

  function automatic logic [7:0] regByte(input logic [3:0] a);
    return regOut[int'(a)*8 +: 8];
  endfunction

  function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [7:0] d,
                              input logic ce, input logic cl, input logic rdy,
                              input logic [15:0] pend, input logic [3:0] ca,
                              input logic [7:0] cb, input logic [7:0] cnt);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.ce = ce; r.cl = cl;
    r.rdy = rdy; r.pend = pend; r.ca = ca; r.cb = cb; r.cnt = cnt;
    return r;
  endfunction

  function automatic void modelReset();
    expQ.delete();
    for (int r = 0; r < 16; r++) mBank[r] = 8'h00;
    mCnt = 0;
  endfunction

  function automatic logic [15:0] modelPending();
    logic [15:0] p;
    p = '0;
    foreach (expQ[i]) if (expQ[i][11:8] != 4'd0) p[expQ[i][11:8]] = 1'b1;
    return p;
  endfunction

  function automatic logic [127:0] modelRegs();
    logic [127:0] f;
    for (int r = 0; r < 16; r++) f[r*8 +: 8] = mBank[r];
    return f;
  endfunction

  // Applies one rising edge to the model; returns whether the push was taken.
  function automatic logic modelEdge(input logic v, input logic [3:0] a, input logic [7:0] d,
                                     input logic ce, input logic cl);
    int          preSz;
    logic        pushOk;
    logic [11:0] e;
    if (cl) begin
      modelReset();
      return 1'b0;
    end
    preSz  = expQ.size();
    pushOk = v && (preSz < DEPTH);
    if (ce && preSz > 0) begin
      e = expQ.pop_front();
      if (e[11:8] != 4'd0) begin
        mBank[e[11:8]] = e[7:0];
        mCnt = (mCnt + 1) % (1 << CNT_W);
      end
    end
    if (pushOk) expQ.push_back({a, d});
    return pushOk;
  endfunction

  logic [7:0]   burstExp [16];
  logic [127:0] burstFlat;
  logic         rv, rce, rcl, held, took;
  logic [3:0]   ra;
  logic [7:0]   rd;

  initial begin
    // Directed vectors, starting from reset
    vecs[0]  = mk(0, 4'h0, 8'h00, 0, 0, 1, 16'h0000, 4'h5, 8'h00, 8'd0);
    vecs[1]  = mk(1, 4'h5, 8'hA7, 1, 0, 1, 16'h0000, 4'h5, 8'h00, 8'd0);
    vecs[2]  = mk(0, 4'h0, 8'h00, 1, 0, 1, 16'h0020, 4'h5, 8'hA7, 8'd1);
    vecs[3]  = mk(0, 4'h0, 8'h00, 0, 0, 1, 16'h0000, 4'h5, 8'hA7, 8'd1);
    vecs[4]  = mk(1, 4'h3, 8'h11, 0, 0, 1, 16'h0000, 4'h3, 8'h00, 8'd1);
    vecs[5]  = mk(1, 4'h3, 8'h22, 0, 0, 1, 16'h0008, 4'h3, 8'h00, 8'd1);
    vecs[6]  = mk(1, 4'h4, 8'h33, 0, 0, 0, 16'h0008, 4'h3, 8'h00, 8'd1);
    vecs[7]  = mk(1, 4'h4, 8'h33, 1, 0, 0, 16'h0008, 4'h3, 8'h11, 8'd2);
    vecs[8]  = mk(1, 4'h4, 8'h33, 1, 0, 1, 16'h0008, 4'h3, 8'h22, 8'd3);
    vecs[9]  = mk(0, 4'h0, 8'h00, 1, 0, 1, 16'h0010, 4'h4, 8'h33, 8'd4);
    vecs[10] = mk(1, 4'h0, 8'hFF, 1, 0, 1, 16'h0000, 4'h0, 8'h00, 8'd4);
    vecs[11] = mk(0, 4'h0, 8'h00, 1, 0, 1, 16'h0000, 4'h0, 8'h00, 8'd4);
    vecs[12] = mk(0, 4'h0, 8'h00, 0, 0, 1, 16'h0000, 4'h0, 8'h00, 8'd4);
    vecs[13] = mk(1, 4'h7, 8'h55, 0, 0, 1, 16'h0000, 4'h7, 8'h00, 8'd4);
    vecs[14] = mk(1, 4'h8, 8'h66, 0, 0, 1, 16'h0080, 4'h7, 8'h00, 8'd4);
    vecs[15] = mk(1, 4'h9, 8'h77, 1, 1, 0, 16'h0180, 4'h3, 8'h00, 8'd0);
    vecs[16] = mk(0, 4'h0, 8'h00, 1, 0, 1, 16'h0000, 4'h7, 8'h00, 8'd0);
    vecs[17] = mk(0, 4'h0, 8'h00, 1, 0, 1, 16'h0000, 4'h8, 8'h00, 8'd0);

    // Reset block
    drive(0, 4'h0, 8'h00, 0, 0);
    rst_n = 1'b0;
    #12;
    check("reset_ready", 128'(wr_ready), 128'(1'b1));
    check("reset_regout", regOut, 128'h0);
    check("reset_pending", 128'(pending), 128'h0);
    check("reset_cnt", 128'(commit_cnt), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].ce, vecs[i].cl);
      #1;
      check($sformatf("vec%0d_ready", i), 128'(wr_ready), 128'(vecs[i].rdy));
      check($sformatf("vec%0d_pending", i), 128'(pending), 128'(vecs[i].pend));
      @(posedge clk); #1;
      check($sformatf("vec%0d_reg%0d", i, vecs[i].ca), 128'(regByte(vecs[i].ca)), 128'(vecs[i].cb));
      check($sformatf("vec%0d_cnt", i), 128'(commit_cnt), 128'(vecs[i].cnt));
    end
    check("after_clr_regout", regOut, 128'h0);

    // Mid-stream asynchronous reset discards buffered writes
    drive(1, 4'h6, 8'h9A, 1, 0);
    @(posedge clk); #1;
    drive(0, 4'h0, 8'h00, 1, 0);
    @(posedge clk); #1;
    check("pre_rst_reg6", 128'(regByte(4'h6)), 128'h9A);
    drive(1, 4'h2, 8'h11, 0, 0);
    @(posedge clk); #1;
    drive(1, 4'h3, 8'h22, 0, 0);
    @(posedge clk); #1;
    check("pre_rst_pending", 128'(pending), 128'h000C);
    check("pre_rst_ready", 128'(wr_ready), 128'h0);
    drive(0, 4'h0, 8'h00, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("in_rst_ready", 128'(wr_ready), 128'h1);
    check("in_rst_regout", regOut, 128'h0);
    check("in_rst_pending", 128'(pending), 128'h0);
    check("in_rst_cnt", 128'(commit_cnt), 128'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("post_rst_regout", regOut, 128'h0);
    check("post_rst_cnt", 128'(commit_cnt), 128'h0);
    check("post_rst_pending", 128'(pending), 128'h0);

    // 300 back-to-back writes with commit enabled; counter wraps through 255
    for (int r = 0; r < 16; r++) burstExp[r] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      drive(1, 4'(1 + i % 15), 8'(i * 7 + 3), 1, 0);
      burstExp[1 + i % 15] = 8'(i * 7 + 3);
      #1;
      check("burst_ready", 128'(wr_ready), 128'h1);
      @(posedge clk); #1;
      if (i == 256) check("burst_wrap_cnt", 128'(commit_cnt), 128'h0);
    end
    drive(0, 4'h0, 8'h00, 1, 0);
    @(posedge clk); #1;
    check("burst_final_cnt", 128'(commit_cnt), 128'(300 % 256));
    for (int r = 0; r < 16; r++) burstFlat[r*8 +: 8] = burstExp[r];
    check("burst_regout", regOut, burstFlat);
    check("burst_pending", 128'(pending), 128'h0);

    // Randomized phase against the reference model
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    modelReset();
    held = 1'b0;
    rv = 1'b0; ra = 4'h0; rd = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      if (!held) begin
        rv = ($urandom_range(0, 3) != 0);
        ra = 4'($urandom_range(0, 15));
        rd = 8'($urandom_range(0, 255));
      end
      // Alternate windows of mostly-stalled and mostly-flowing commits
      rce = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rcl = ($urandom_range(0, 63) == 0);
      drive(rv, ra, rd, rce, rcl);
      #1;
      check("rand_ready", 128'(wr_ready), 128'(expQ.size() < DEPTH));
      check("rand_pending", 128'(pending), 128'(modelPending()));
      @(posedge clk);
      took = modelEdge(rv, ra, rd, rce, rcl);
      held = rv && !took;
      #1;
      check("rand_regout", regOut, modelRegs());
      check("rand_cnt", 128'(commit_cnt), 128'(mCnt));
    end

    // Final report
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
